// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// 1-entry skid buffer for responses that arrive while decode is stalled,
// and the IF/ID pipeline register feeding decode and the hazard unit.
module fetch_stage #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    REGADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pc_write,
    input  logic                     if_id_write,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     if_id_valid,
    output logic [ADDR_WIDTH-1:0]    if_id_pc,
    output logic [31:0]              if_id_instr,
    output logic [REGADDR_WIDTH-1:0] if_id_rs,
    output logic [REGADDR_WIDTH-1:0] if_id_rt
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]            state_q,       state_d;
    logic [ADDR_WIDTH-1:0] pc_q,          pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q,      req_pc_d;
    logic                  skid_valid_q,  skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q,     skid_pc_d;
    logic [31:0]           skid_instr_q,  skid_instr_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic [ADDR_WIDTH-1:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0]           if_id_instr_q, if_id_instr_d;

    logic accept;
    logic deliver;

    // A request may only go out when idle, not stalled, the skid is empty
    // and no redirect is pending; a response is only usable in S_WAIT
    // when no redirect kills it in the same cycle.
    assign imem_req  = ~rst & (state_q == S_REQ) & pc_write & ~skid_valid_q & ~redirect_valid;
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;
    assign deliver   = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid;

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_rs    = if_id_instr_q[15 +: REGADDR_WIDTH];
    assign if_id_rt    = if_id_instr_q[20 +: REGADDR_WIDTH];

    // Next-state logic for the fetch FSM, PC, skid buffer and IF/ID register.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (accept) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end

        if (accept) begin
            req_pc_d = pc_q;
        end

        if (redirect_valid) begin
            skid_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
        end else if (if_id_write) begin
            if (skid_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = skid_pc_q;
                if_id_instr_d = skid_instr_q;
                skid_valid_d  = 1'b0;
            end else if (deliver) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = req_pc_q;
                if_id_instr_d = imem_rdata;
            end else begin
                if_id_valid_d = 1'b0;
            end
        end else if (deliver) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rdata;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a memory model answers
// accepted requests with random latency, and the expected instruction
// stream is simply program order from the last reset/redirect target.
module tb_fetch_stage;

    localparam int AW = 32;
    localparam int RW = 4;
    localparam int NUM_CYCLES = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_write;
    logic          if_id_write;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          if_id_valid;
    logic [AW-1:0] if_id_pc;
    logic [31:0]   if_id_instr;
    logic [RW-1:0] if_id_rs;
    logic [RW-1:0] if_id_rt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;
    int idle     = 0;
    bit mon_en   = 1'b0;

    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          since_redirect = 0;

    fetch_stage #(
        .ADDR_WIDTH    (AW),
        .REGADDR_WIDTH (RW),
        .RESET_PC      (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt)
    );

    always #5 clk = ~clk;

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A3_0333;
    endfunction

    // Program order from a new start address; older expectations are dead.
    function automatic void restart_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_t e;
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model, hazard-unit stalls and redirects for the next cycle.
    task automatic apply_stimulus(input bit acc, input logic [31:0] acc_addr);
        if (imem_rvalid) begin
            imem_rvalid = 1'b0;
            mem_busy    = 1'b0;
        end
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = int'($urandom_range(1, 3));
        end
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
            end
        end else if ($urandom_range(0, 9) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        imem_ready  = ($urandom_range(0, 3) != 0);
        pc_write    = ($urandom_range(0, 3) != 0);
        if_id_write = ($urandom_range(0, 3) != 0);
        since_redirect++;
        if (since_redirect >= 80 || $urandom_range(0, 14) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            restart_stream(redirect_pc);
            since_redirect = 0;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    // Monitor: decode consumes IF/ID whenever it is valid, written and not flushed.
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_id_valid && if_id_write && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("stream_underflow", if_id_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("if_id_pc", if_id_pc, e.pc);
                    check_output("if_id_instr", if_id_instr, e.instr);
                    check_output("if_id_rs_rt", {24'h0, if_id_rs, if_id_rt},
                                 {24'h0, e.instr[18:15], e.instr[23:20]});
                end
                consumed++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 300) begin
                    check_output("progress_watchdog", 32'(idle), 32'd300);
                    idle = 0;
                end
            end
        end
    end

    // Reset checks, then the randomized run, then the summary.
    initial begin
        bit          acc;
        logic [31:0] acc_addr;
        rst            = 1'b1;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        repeat (3) begin
            @(negedge clk);
            check_output("reset_imem_req", 32'(imem_req), 32'd0);
            check_output("reset_if_id_valid", 32'(if_id_valid), 32'd0);
            check_output("reset_if_id_instr", if_id_instr, 32'h0000_0013);
            check_output("reset_if_id_pc", if_id_pc, 32'h0);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        restart_stream(32'h0);
        mon_en = 1'b1;

        for (int cycle = 0; cycle < NUM_CYCLES; cycle++) begin
            @(negedge clk);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            if (cycle == 0) begin
                check_output("first_req", 32'(imem_req), 32'd1);
                check_output("first_addr", imem_addr, 32'h0);
            end
            if (redirect_valid || !pc_write) begin
                check_output("req_blocked", 32'(imem_req), 32'd0);
            end
            if (acc) begin
                check_output("single_outstanding", 32'(mem_busy), 32'd0);
            end
            @(posedge clk);
            #1;
            apply_stimulus(acc, acc_addr);
        end

        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (consumed < 50) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d instructions, expected at least 50", consumed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
